// File: rtl/axi_req_sched.sv
// axi_req_sched: arbitrates instruction/data read requests onto the AXI AR
// channel, hands data writes to the write-channel engine, counts outstanding
// reads and holds back reads that would overtake a pending write to the same
// 16-byte line.
module axi_req_sched #(
    parameter int MAX_RD = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inst_rd_req,
    input  logic [31:0]  inst_rd_addr,
    input  logic [1:0]   inst_rd_size,
    input  logic [7:0]   inst_rd_len,
    output logic         inst_rd_grant,
    input  logic         data_rd_req,
    input  logic [31:0]  data_rd_addr,
    input  logic [1:0]   data_rd_size,
    input  logic [7:0]   data_rd_len,
    output logic         data_rd_grant,
    input  logic         data_wr_req,
    input  logic [31:0]  data_wr_addr,
    input  logic [1:0]   data_wr_size,
    input  logic [7:0]   data_wr_len,
    input  logic [3:0]   data_wr_strb,
    input  logic [127:0] data_wr_data,
    output logic         data_wr_grant,
    output logic [1:0]   we_id,
    output logic [31:0]  we_addr,
    output logic [1:0]   we_size,
    output logic [7:0]   we_len,
    output logic [3:0]   we_strb,
    output logic [127:0] we_data,
    input  logic         we_addr_ok,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic         rvalid,
    input  logic         rready,
    input  logic         rlast,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT_B} w_state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_RD);

    ar_state_t  ar_state;
    w_state_t   w_state;
    logic [3:0] rd_cnt;
    logic       rr_last;      // 1: data side was granted last
    logic       inst_blk;
    logic       data_blk;
    logic       inst_elig;
    logic       data_elig;
    logic       ar_hs;
    logic       r_done;

    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign bready  = 1'b1;

    assign ar_hs  = arvalid && arready;
    assign r_done = rvalid && rready && rlast;

    // Grant decisions: write first on the data side, then RAW filtering and
    // round-robin between the two read sides.
    always_comb begin
        data_wr_grant = (w_state == W_IDLE) && data_wr_req;
        inst_blk = ((w_state != W_IDLE) && (inst_rd_addr[31:4] == we_addr[31:4])) ||
                   (data_wr_grant && (inst_rd_addr[31:4] == data_wr_addr[31:4]));
        data_blk = ((w_state != W_IDLE) && (data_rd_addr[31:4] == we_addr[31:4])) ||
                   (data_wr_grant && (data_rd_addr[31:4] == data_wr_addr[31:4]));
        inst_elig = inst_rd_req && (ar_state == AR_IDLE) && (rd_cnt < MAX_CNT) && !inst_blk;
        data_elig = data_rd_req && (ar_state == AR_IDLE) && (rd_cnt < MAX_CNT) && !data_blk;
        inst_rd_grant = inst_elig && (!data_elig || rr_last);
        data_rd_grant = data_elig && (!inst_elig || !rr_last);
    end

    // Read FSM: register the granted request and present it on AR until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
            arid     <= 4'd0;
            araddr   <= 32'd0;
            arlen    <= 8'd0;
            arsize   <= 3'd0;
            rr_last  <= 1'b1;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (inst_rd_grant) begin
                        ar_state <= AR_BUSY;
                        arvalid  <= 1'b1;
                        arid     <= 4'd0;
                        araddr   <= inst_rd_addr;
                        arlen    <= inst_rd_len;
                        arsize   <= {1'b0, inst_rd_size};
                        rr_last  <= 1'b0;
                    end else if (data_rd_grant) begin
                        ar_state <= AR_BUSY;
                        arvalid  <= 1'b1;
                        arid     <= 4'd1;
                        araddr   <= data_rd_addr;
                        arlen    <= data_rd_len;
                        arsize   <= {1'b0, data_rd_size};
                        rr_last  <= 1'b1;
                    end
                end
                AR_BUSY: begin
                    if (arready) begin
                        ar_state <= AR_IDLE;
                        arvalid  <= 1'b0;
                    end
                end
                default: begin
                    ar_state <= AR_IDLE;
                    arvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding read counter, saturating at both ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= 4'd0;
        end else if (ar_hs && !r_done && (rd_cnt != MAX_CNT)) begin
            rd_cnt <= rd_cnt + 4'd1;
        end else if (!ar_hs && r_done && (rd_cnt != 4'd0)) begin
            rd_cnt <= rd_cnt - 4'd1;
        end
    end

    // Write FSM: capture one write, offer it to the engine, wait for its B response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            we_id   <= 2'b00;
            we_addr <= 32'd0;
            we_size <= 2'd0;
            we_len  <= 8'd0;
            we_strb <= 4'd0;
            we_data <= 128'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_grant) begin
                        w_state <= W_ISSUE;
                        we_id   <= 2'b10;
                        we_addr <= data_wr_addr;
                        we_size <= data_wr_size;
                        we_len  <= data_wr_len;
                        we_strb <= data_wr_strb;
                        we_data <= data_wr_data;
                    end
                end
                W_ISSUE: begin
                    if (we_addr_ok) begin
                        w_state <= W_WAIT_B;
                        we_id   <= 2'b00;
                    end
                end
                W_WAIT_B: begin
                    if (bvalid) begin
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    we_id   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_req_sched.sv
// Bench for axi_req_sched: directed scenarios followed by a randomized phase,
// all outputs compared every cycle against a transaction-level model.
module tb_axi_req_sched;

    localparam int MAX_RD = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         inst_rd_req, data_rd_req, data_wr_req;
    logic [31:0]  inst_rd_addr, data_rd_addr, data_wr_addr;
    logic [1:0]   inst_rd_size, data_rd_size, data_wr_size;
    logic [7:0]   inst_rd_len, data_rd_len, data_wr_len;
    logic [3:0]   data_wr_strb;
    logic [127:0] data_wr_data;
    logic         inst_rd_grant, data_rd_grant, data_wr_grant;
    logic [1:0]   we_id, we_size;
    logic [31:0]  we_addr;
    logic [7:0]   we_len;
    logic [3:0]   we_strb;
    logic [127:0] we_data;
    logic         we_addr_ok;
    logic [3:0]   arid, arcache;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, arlock;
    logic         arvalid, arready, rvalid, rready, rlast, bvalid, bready;

    axi_req_sched #(.MAX_RD(MAX_RD)) dut (
        .clk(clk), .resetn(resetn),
        .inst_rd_req(inst_rd_req), .inst_rd_addr(inst_rd_addr), .inst_rd_size(inst_rd_size),
        .inst_rd_len(inst_rd_len), .inst_rd_grant(inst_rd_grant),
        .data_rd_req(data_rd_req), .data_rd_addr(data_rd_addr), .data_rd_size(data_rd_size),
        .data_rd_len(data_rd_len), .data_rd_grant(data_rd_grant),
        .data_wr_req(data_wr_req), .data_wr_addr(data_wr_addr), .data_wr_size(data_wr_size),
        .data_wr_len(data_wr_len), .data_wr_strb(data_wr_strb), .data_wr_data(data_wr_data),
        .data_wr_grant(data_wr_grant),
        .we_id(we_id), .we_addr(we_addr), .we_size(we_size), .we_len(we_len),
        .we_strb(we_strb), .we_data(we_data), .we_addr_ok(we_addr_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one pending AR slot, a count of reads in flight,
    // a write phase (0 none, 1 offered to engine, 2 awaiting B) and the side served last.
    bit           m_ar_busy;
    logic [3:0]   m_arid;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    int           m_out;
    int           m_wph;
    logic [31:0]  m_waddr;
    logic [1:0]   m_wsize;
    logic [7:0]   m_wlen;
    logic [3:0]   m_wstrb;
    logic [127:0] m_wdata;
    bit           m_last_data;
    bit           e_ig, e_dg, e_wg;
    bit           obs_ig, obs_dg, obs_wg;
    logic [1:0]   obs_weid;
    logic [3:0]   ar_log[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ar_busy = 0; m_arid = 0; m_araddr = 0; m_arlen = 0; m_arsize = 0;
        m_out = 0; m_wph = 0; m_waddr = 0; m_wsize = 0; m_wlen = 0; m_wstrb = 0;
        m_wdata = 0; m_last_data = 1;
    endtask

    function automatic bit same_line(logic [31:0] a, logic [31:0] b);
        return (a >> 4) == (b >> 4);
    endfunction

    function automatic bit raw_blocked(logic [31:0] a);
        return (m_wph != 0 && same_line(a, m_waddr)) || (e_wg && same_line(a, data_wr_addr));
    endfunction

    task automatic predict();
        bit ie, de;
        e_wg = (m_wph == 0) && data_wr_req;
        ie = inst_rd_req && !m_ar_busy && (m_out < MAX_RD) && !raw_blocked(inst_rd_addr);
        de = data_rd_req && !m_ar_busy && (m_out < MAX_RD) && !raw_blocked(data_rd_addr);
        e_ig = 0; e_dg = 0;
        if (ie && de) begin
            if (m_last_data) e_ig = 1; else e_dg = 1;
        end else begin
            e_ig = ie; e_dg = de;
        end
    endtask

    task automatic m_update();
        if (m_ar_busy && arready) begin
            m_ar_busy = 0;
            m_out++;
        end
        if (rvalid && rready && rlast && m_out > 0) m_out--;
        if (e_ig || e_dg) begin
            m_ar_busy   = 1;
            m_arid      = e_dg ? 4'd1 : 4'd0;
            m_araddr    = e_dg ? data_rd_addr : inst_rd_addr;
            m_arlen     = e_dg ? data_rd_len : inst_rd_len;
            m_arsize    = {1'b0, (e_dg ? data_rd_size : inst_rd_size)};
            m_last_data = e_dg;
        end
        if (m_wph == 0 && e_wg) begin
            m_wph = 1; m_waddr = data_wr_addr; m_wsize = data_wr_size; m_wlen = data_wr_len;
            m_wstrb = data_wr_strb; m_wdata = data_wr_data;
        end else if (m_wph == 1 && we_addr_ok) begin
            m_wph = 2;
        end else if (m_wph == 2 && bvalid) begin
            m_wph = 0;
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        predict();
        @(negedge clk);
        obs_ig = inst_rd_grant; obs_dg = data_rd_grant; obs_wg = data_wr_grant; obs_weid = we_id;
        chk("inst_rd_grant", inst_rd_grant, e_ig);
        chk("data_rd_grant", data_rd_grant, e_dg);
        chk("data_wr_grant", data_wr_grant, e_wg);
        chk("arvalid", arvalid, m_ar_busy);
        chk("arid", arid, m_arid);
        chk("araddr", araddr, m_araddr);
        chk("arlen", arlen, m_arlen);
        chk("arsize", arsize, m_arsize);
        chk("we_id", we_id, (m_wph == 1) ? 2'b10 : 2'b00);
        chk("we_addr", we_addr, m_waddr);
        chk("we_size_len_strb", {we_size, we_len, we_strb}, {m_wsize, m_wlen, m_wstrb});
        chk("we_data", we_data, m_wdata);
        chk("rd_cnt", dut.rd_cnt, 4'(m_out));
        chk("ar_consts", {arburst, arlock, arcache, arprot, bready}, {2'b01, 2'b00, 4'b0000, 3'b000, 1'b1});
        if (arvalid && arready) ar_log.push_back(arid);
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_idle();
        inst_rd_req = 0; inst_rd_addr = 0; inst_rd_size = 0; inst_rd_len = 0;
        data_rd_req = 0; data_rd_addr = 0; data_rd_size = 0; data_rd_len = 0;
        data_wr_req = 0; data_wr_addr = 0; data_wr_size = 0; data_wr_len = 0;
        data_wr_strb = 0; data_wr_data = 0;
        we_addr_ok = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0; bvalid = 0;
    endtask

    task automatic drain_reads();
        rvalid = 1; rready = 1; rlast = 1;
        repeat (MAX_RD) step();
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_issue;
        set_idle();
        resetn = 0;
        m_reset();
        #12;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_ar_fields", {arid, araddr, arlen, arsize}, '0);
        chk("rst_we_id", we_id, 2'b00);
        chk("rst_we_fields", {we_addr, we_size, we_len, we_strb}, '0);
        chk("rst_we_data", we_data, '0);
        chk("rst_grants", {inst_rd_grant, data_rd_grant, data_wr_grant}, 3'b000);
        chk("rst_bready", bready, 1'b1);
        chk("rst_rd_cnt", dut.rd_cnt, 4'd0);
        @(posedge clk); #1;
        resetn = 1;

        // Round-robin between two always-requesting read sides.
        ar_log.delete();
        inst_rd_req = 1; inst_rd_addr = 32'h1000; inst_rd_size = 2; inst_rd_len = 3;
        data_rd_req = 1; data_rd_addr = 32'h2000; data_rd_size = 1; data_rd_len = 1;
        arready = 1; rvalid = 1; rready = 1; rlast = 1;
        repeat (8) step();
        chk("rr_count", ar_log.size(), 4);
        for (int i = 0; i < 4 && i < ar_log.size(); i++) chk("rr_arid", ar_log[i], 4'(i % 2));
        set_idle();
        step();

        // Outstanding limit.
        inst_rd_req = 1; inst_rd_addr = 32'h3000; arready = 1;
        repeat (4) step();
        step(); chk("max_rd_block0", obs_ig, 1'b0);
        step(); chk("max_rd_block1", obs_ig, 1'b0);
        rvalid = 1; rready = 1; rlast = 1;
        step(); chk("max_rd_rlast_cycle", obs_ig, 1'b0);
        rvalid = 0; rready = 0; rlast = 0;
        step(); chk("max_rd_regrant", obs_ig, 1'b1);
        inst_rd_req = 0;
        step();
        drain_reads();

        // Write offered for four cycles while the engine is busy.
        data_wr_req = 1; data_wr_addr = 32'h8000_0010; data_wr_size = 2; data_wr_len = 3;
        data_wr_strb = 4'hf; data_wr_data = {$urandom, $urandom, $urandom, $urandom};
        we_addr_ok = 0;
        step(); chk("wr_grant", obs_wg, 1'b1);
        data_wr_req = 0; data_wr_addr = 32'hdead_beef; data_wr_data = '0;
        n_issue = 0;
        repeat (3) begin step(); if (obs_weid == 2'b10) n_issue++; end
        we_addr_ok = 1;
        step(); if (obs_weid == 2'b10) n_issue++;
        we_addr_ok = 0;
        step(); if (obs_weid == 2'b10) n_issue++;
        chk("wr_issue_cycles", n_issue, 4);
        bvalid = 1; step(); bvalid = 0;
        data_wr_addr = 0;

        // Read after pending write to the same line.
        data_wr_req = 1; data_wr_addr = 32'h8000_0014; we_addr_ok = 1;
        step();
        data_wr_req = 0;
        step();
        we_addr_ok = 0;
        inst_rd_req = 1; inst_rd_addr = 32'h8000_001C;
        data_rd_req = 1; data_rd_addr = 32'h8000_0020; arready = 1;
        step(); chk("raw_inst_blocked", obs_ig, 1'b0); chk("raw_other_line", obs_dg, 1'b1);
        data_rd_req = 0;
        step();
        step(); chk("raw_hold0", obs_ig, 1'b0);
        step(); chk("raw_hold1", obs_ig, 1'b0);
        bvalid = 1;
        step(); chk("raw_b_cycle", obs_ig, 1'b0);
        bvalid = 0;
        step(); chk("raw_after_b", obs_ig, 1'b1);
        inst_rd_req = 0;
        step();
        drain_reads();

        // Same-cycle data read and write to one line.
        data_wr_req = 1; data_wr_addr = 32'h8000_0040;
        data_rd_req = 1; data_rd_addr = 32'h8000_0048;
        step(); chk("ord_wr", obs_wg, 1'b1); chk("ord_rd", obs_dg, 1'b0);
        data_wr_req = 0;
        step(); chk("ord_rd_issue", obs_dg, 1'b0);
        we_addr_ok = 1;
        step(); chk("ord_rd_capture", obs_dg, 1'b0);
        we_addr_ok = 0;
        step(); chk("ord_rd_waitb", obs_dg, 1'b0);
        bvalid = 1;
        step(); chk("ord_rd_b", obs_dg, 1'b0);
        bvalid = 0;
        step(); chk("ord_rd_after_b", obs_dg, 1'b1);
        data_rd_req = 0;
        step();
        drain_reads();

        // Randomized traffic; requests stay up (with stable fields) until granted.
        for (int i = 0; i < 400; i++) begin
            if (!inst_rd_req || e_ig) begin
                inst_rd_req = 1'($urandom_range(0, 1)); inst_rd_addr = rand_addr();
                inst_rd_size = 2'($urandom); inst_rd_len = 8'($urandom);
            end
            if (!data_rd_req || e_dg) begin
                data_rd_req = 1'($urandom_range(0, 1)); data_rd_addr = rand_addr();
                data_rd_size = 2'($urandom); data_rd_len = 8'($urandom);
            end
            if (!data_wr_req || e_wg) begin
                data_wr_req = ($urandom_range(0, 3) == 0); data_wr_addr = rand_addr();
                data_wr_size = 2'($urandom); data_wr_len = 8'($urandom);
                data_wr_strb = 4'($urandom);
                data_wr_data = {$urandom, $urandom, $urandom, $urandom};
            end
            arready = 1'($urandom_range(0, 1));
            we_addr_ok = 1'($urandom_range(0, 1));
            bvalid = ($urandom_range(0, 2) == 0);
            rvalid = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
            rlast = ($urandom_range(0, 2) == 0);
            step();
        end

        // Settle, then assert reset while a read and a write are in flight.
        set_idle();
        arready = 1; we_addr_ok = 1; bvalid = 1;
        repeat (6) step();
        set_idle();
        drain_reads();
        inst_rd_req = 1; inst_rd_addr = 32'h5000;
        data_wr_req = 1; data_wr_addr = 32'h9000;
        step(); chk("par_rd", obs_ig, 1'b1); chk("par_wr", obs_wg, 1'b1);
        inst_rd_req = 0; data_wr_req = 0;
        step();
        #2;
        resetn = 0;
        #1;
        chk("arst_arvalid", arvalid, 1'b0);
        chk("arst_we_id", we_id, 2'b00);
        chk("arst_rd_cnt", dut.rd_cnt, 4'd0);
        chk("arst_we_addr", we_addr, 32'd0);
        m_reset();
        #3;
        resetn = 1;
        @(posedge clk); #1;
        inst_rd_req = 1; inst_rd_addr = 32'h6000;
        step(); chk("arst_first_grant", obs_ig, 1'b1);
        inst_rd_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_req_sched.md
# axi_req_sched

Request scheduler in front of the AXI bridge. It arbitrates instruction-side and data-side read requests onto the shared AR channel and hands data-side write requests to the write-channel engine. It also tracks outstanding reads and the single outstanding write, and blocks reads that would overtake a pending write to the same 16-byte line. It sits between the cache-side request ports and the AXI AR / write-engine / B / R-completion signals.

## Interface
Parameters:
- MAX_RD, 2: maximum AR transactions outstanding (counted until rlast); 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- inst_rd_req  in  1  instruction read request; held until granted.
- inst_rd_addr  in  32  instruction read address.
- inst_rd_size  in  2  log2 bytes per beat.
- inst_rd_len  in  8  beats minus one.
- inst_rd_grant  out  1  combinational accept; request taken at this edge.
- data_rd_req / data_rd_addr / data_rd_size / data_rd_len / data_rd_grant  same widths and meaning as the inst_rd_* ports, data side.
- data_wr_req  in  1  data write request; held until granted.
- data_wr_addr  in  32  write address.
- data_wr_size  in  2  log2 bytes per beat.
- data_wr_len  in  8  beats minus one.
- data_wr_strb  in  4  byte strobe.
- data_wr_data  in  128  write data, beat n in bits [32n+31:32n].
- data_wr_grant  out  1  combinational accept.
- we_id  out  2  2'b10 while offering a write to the engine, else 2'b00.
- we_addr  out  32  registered write command to the engine.
- we_size  out  2  registered write command to the engine.
- we_len  out  8  registered write command to the engine.
- we_strb  out  4  registered write command to the engine.
- we_data  out  128  registered write command to the engine.
- we_addr_ok  in  1  engine idle; command is captured on an edge where we_id==2'b10 and this is high.
- arid  out  4  0 = inst, 1 = data.
- araddr  out  32  AR address.
- arlen  out  8  AR burst length.
- arsize  out  3  AR beat size.
- arburst  out  2  constant 2'b01.
- arlock  out  2  constant 2'b00.
- arcache  out  4  constant 4'b0000.
- arprot  out  3  constant 3'b000.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rvalid  in  1  R-channel handshake, observed only.
- rready  in  1  R-channel handshake, observed only.
- rlast  in  1  R-channel handshake, observed only.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

## Operation
Read FSM, states AR_IDLE and AR_BUSY:
- AR_IDLE: a read is eligible if its req is high, rd_cnt < MAX_RD, and it is not RAW-blocked.
- If both reads are eligible, round-robin: grant the side not granted last. rr_last resets to data, so inst wins the first tie.
- On grant: register arid, araddr, arlen, and arsize={1'b0,size}; update rr_last; go to AR_BUSY.
- AR_BUSY: arvalid=1 with fields stable. On arready go to AR_IDLE; no new grant in that same cycle.

Write FSM, states W_IDLE, W_ISSUE and W_WAIT_B:
- W_IDLE: on data_wr_req, data_wr_grant=1, capture all we_* fields, go to W_ISSUE.
- W_ISSUE: we_id=2'b10. On we_addr_ok go to W_WAIT_B; we_id returns to 2'b00 the next cycle.
- W_WAIT_B: on bvalid go to W_IDLE. bready is constant 1.
- Only one write is outstanding; data_wr_req is ignored outside W_IDLE.

RAW block:
- A read is blocked when its addr[31:4] equals the pending write line and the write FSM is not in W_IDLE.
- A read is also blocked when its addr[31:4] equals data_wr_addr[31:4] while data_wr_grant is high in the same cycle.

Data-side ordering:
- If data_rd_req and data_wr_req are both high in the same cycle, the write is granted. The data read is then RAW-checked against it.

rd_cnt (4 bits):
- +1 on arvalid&&arready.
- −1 on rvalid&&rready&&rlast.
- Both events in the same cycle leave it unchanged.
- Never exceeds MAX_RD and never wraps.

## Timing
- Reset values: arvalid=0, arid=0, araddr=0, arlen=0, arsize=0, we_id=0, all we_* fields 0, all grants 0, rd_cnt=0, both FSMs idle, bready=1.
- Reset is asynchronous; asserting it mid-transaction drops arvalid and we_id immediately. Outstanding AXI state is discarded; the system resets as a whole.
- AR latency: grant edge, then arvalid on the next cycle. The minimum interval between AR handshakes is 2 cycles.
- Write latency: grant edge, then we_id=2'b10 on the next cycle. The earliest engine capture is that cycle's edge.
- Grants depend combinationally on req, FSM state, rd_cnt and addresses; there are no combinational paths from arready or we_addr_ok to grants.
- A read and a write may be granted in the same cycle (different sides, different lines).

## Test plan
- Reset mid-AR_BUSY (arvalid=1): resetn low -> arvalid=0 immediately, rd_cnt=0; after release, inst_rd_req high -> grant in the first cycle.
- Both reads requested at 0x1000 and 0x2000, arready always 1 -> arid sequence 0,1,0,1; each AR follows its grant by 1 cycle.
- MAX_RD=2: two ARs accepted with no rlast -> third request gets no grant; one rlast beat -> grant in the next cycle.
- Write to 0x80000010 with len=3, we_addr_ok low for 3 cycles -> we_id=2'b10 held 4 cycles; fields stable; single capture edge.
- Pending write to 0x80000014, inst read of 0x8000001C -> blocked until bvalid; grant in the cycle after the B handshake. A read of 0x80000020 is granted immediately.
- data_rd_req and data_wr_req both high, same line -> data_wr_grant=1, data_rd_grant=0 until the B handshake.
